id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

ID/EX pipeline register of the 64-bit core, sitting directly upstream of `ALU_64_bit`. It captures decoded operands, immediate, register indices and control bits at the end of ID. It also generates the 4-bit ALU operation code from the 2-bit main-decoder `alu_op` and the instruction funct bits, so the ALU sees a registered, glitch-free `ALUOp` at the start of EX. It supports hazard-unit stall (hold), flush (bubble insertion) and a saturating stall-cycle counter for performance debug.

## Interface
- `XLEN`, 64, data/PC/immediate width
- `REGW`, 5, register index width
- `CNTW`, 32, stall counter width
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: ID holds a real instruction
- `stall` in 1: hold all registers this cycle
- `flush` in 1: replace the contents with a bubble this cycle
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN: ID data fields
- `id_rs1`, `id_rs2`, `id_rd` in REGW: register indices
- `id_funct` in 4: {instr[30], instr[14:12]}
- `id_alu_op` in 2: main-decoder ALU class
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch` in 1 each: control bits
- `ex_*` out (same widths): registered copies of every `id_*` field except `id_funct` and `id_alu_op`
- `ex_valid` out 1: EX holds a real instruction
- `ex_alu_ctl` out 4: drives ALU `ALUOp`
- `ex_alu_b` out XLEN: `id_alu_src ? id_imm : id_rs2_data`, registered
- `ex_illegal` out 1: funct combination not decodable
- `stall_count` out CNTW: saturating count of stalled cycles

## Operation
- Per-edge priority: reset > flush > stall > load.
  - reset: all outputs 0, including `stall_count` and `ex_alu_ctl = 0000`.
  - flush: bubble, i.e. every `ex_*` output 0, `ex_valid = 0`, `ex_illegal = 0`. `stall_count` is unchanged.
  - stall (no flush): all `ex_*` outputs hold. `stall_count` increments by 1 and saturates at all-ones.
  - load: capture all fields, with `ex_valid = in_valid`. If `in_valid = 0`, the load is a bubble identical to flush.
- ALU control decode, combinational on the `id_*` inputs and registered into `ex_alu_ctl`:
  - `alu_op 00` → 0010 (ADD: loads, stores, address calculation)
  - `alu_op 01` → 0110 (SUB: branch compare)
  - `alu_op 11` → 1100 (NOR)
  - `alu_op 10` decodes on funct:
    - 0_000 → 0010
    - 1_000 → 0110
    - 0_111 → 0000 (AND)
    - 0_110 → 0001 (OR)
    - any other funct → 1111 with `ex_illegal = 1`. The ALU default then yields Result 0.
- `ex_illegal` is only set when the captured instruction is valid.
- Stall with flush asserted together: flush wins, and the counter does not increment.

## Timing
- Latency of 1 cycle from `id_*` to `ex_*`. There is no combinational path from inputs to outputs.
- `stall` and `flush` are sampled on the same edge as the data.
- After deassertion of `reset`, the first edge with `in_valid = 1` produces `ex_valid = 1` on the next cycle.
- Counter wrap is forbidden; it holds at 2^CNTW−1.
- A reset arriving mid-stall clears everything on that edge, and the held instruction is lost.

## Structure
- Shared package `core_pkg`:
  - ALU op constants (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1111 INVALID)
  - `alu_op` class constants
  - XLEN/REGW defaults
- One sub-module `alu_ctl_decode`: purely combinational, with inputs `alu_op` and `funct`, and outputs `alu_ctl` and `illegal`. It is reused by the single-cycle datapath.
- The top contains the register bank, the operand-B mux and the stall counter.

## Test plan
- Reset, then load ADD: `id_alu_op=10`, funct 0_000, rs1=5, rs2=7, `alu_src=0`, `in_valid=1`. Next cycle requires `ex_alu_ctl=0010`, `ex_alu_b=7`, `ex_valid=1`. When fed into the ALU, Result=12.
- I-type with `alu_src=1`, imm=0xFFFF_FFFF_FFFF_FFF0, `alu_op=00` → `ex_alu_b=imm`, `ex_alu_ctl=0010`.
- Load SUB (1_000), then assert `stall` for 3 cycles with changing inputs → outputs stay at SUB values, `stall_count=3`. The following load captures the new inputs.
- Stall and flush asserted in the same cycle → `ex_valid=0`, all control 0, `stall_count` unchanged.
- `alu_op=10`, funct 0_011 → `ex_alu_ctl=1111`, `ex_illegal=1`. The same with `in_valid=0` → `ex_illegal=0`.
- Preload the counter to all-ones via forced stall, then stall once more → `stall_count` stays 0xFFFF_FFFF. Reset on the next edge → 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 64-bit core: datapath width defaults,
// main-decoder ALU classes, R-type funct codes and ALU operation codes.
package core_pkg;

    localparam int XLEN_DEF = 64;
    localparam int REGW_DEF = 5;
    localparam int CNTW_DEF = 32;

    // Operation codes understood by ALU_64_bit on its ALUOp input.
    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_NOR     = 4'b1100,
        ALU_INVALID = 4'b1111
    } alu_ctl_e;

    // Instruction class produced by the main decoder.
    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_NOR    = 2'b11
    } alu_op_e;

    // R-type funct codes, {instr[30], instr[14:12]}.
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b1000;
    localparam logic [3:0] FUNCT_AND = 4'b0111;
    localparam logic [3:0] FUNCT_OR  = 4'b0110;

endpackage : core_pkg

// File: rtl/alu_ctl_decode.sv
// ALU control decoder: maps the main-decoder class and the R-type funct bits
// to a 4-bit ALU operation. Purely combinational so the single-cycle datapath
// can reuse it unchanged.
module alu_ctl_decode
    import core_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [3:0] funct,
    output logic [3:0] alu_ctl,
    output logic       illegal
);

    // Select the ALU operation; unknown R-type funct yields INVALID and illegal.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
        alu_ctl = ALU_ADD;
        illegal = 1'b0;
        case (alu_op_e'(alu_op))
            ALUOP_MEM:    alu_ctl = ALU_ADD;
            ALUOP_BRANCH: alu_ctl = ALU_SUB;
            ALUOP_NOR:    alu_ctl = ALU_NOR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    default: begin
                        alu_ctl = ALU_INVALID;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule : alu_ctl_decode

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Captures decoded operands and control, registers
// the decoded ALU operation and operand B, and supports stall, flush and a
// saturating stalled-cycle counter. Edge priority: reset > flush > stall > load.
module id_ex_stage_reg
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [3:0]      id_funct,
    input  logic [1:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [REGW-1:0] ex_rs1,
    output logic [REGW-1:0] ex_rs2,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_ctl,
    output logic [XLEN-1:0] ex_alu_b,
    output logic            ex_illegal,
    output logic [CNTW-1:0] stall_count
);

    logic [3:0] dec_alu_ctl;
    logic       dec_illegal;

    alu_ctl_decode u_alu_ctl_decode (
        .alu_op  (id_alu_op),
        .funct   (id_funct),
        .alu_ctl (dec_alu_ctl),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q, alu_b_q;
    logic [XLEN-1:0] pc_d, rs1_data_d, rs2_data_d, imm_d, alu_b_d;
    logic [REGW-1:0] rs1_q, rs2_q, rd_q, rs1_d, rs2_d, rd_d;
    logic [3:0]      alu_ctl_q, alu_ctl_d;
    logic            valid_q, illegal_q, alu_src_q, mem_read_q, mem_write_q;
    logic            valid_d, illegal_d, alu_src_d, mem_read_d, mem_write_d;
    logic            reg_write_q, mem_to_reg_q, branch_q;
    logic            reg_write_d, mem_to_reg_d, branch_d;
    logic [CNTW-1:0] stall_count_q, stall_count_d;

    // Next state: bubble on flush or invalid load, hold and count on stall, else capture.
    always_comb begin
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        alu_b_d       = alu_b_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        alu_ctl_d     = alu_ctl_q;
        valid_d       = valid_q;
        illegal_d     = illegal_q;
        alu_src_d     = alu_src_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        reg_write_d   = reg_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        branch_d      = branch_q;
        stall_count_d = stall_count_q;

        if (flush || (!stall && !in_valid)) begin
            pc_d         = '0;
            rs1_data_d   = '0;
            rs2_data_d   = '0;
            imm_d        = '0;
            alu_b_d      = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
            alu_ctl_d    = '0;
            valid_d      = 1'b0;
            illegal_d    = 1'b0;
            alu_src_d    = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            branch_d     = 1'b0;
        end else if (stall) begin
            if (stall_count_q != '1) begin
                stall_count_d = stall_count_q + CNTW'(1);
            end
        end else begin
            pc_d         = id_pc;
            rs1_data_d   = id_rs1_data;
            rs2_data_d   = id_rs2_data;
            imm_d        = id_imm;
            alu_b_d      = id_alu_src ? id_imm : id_rs2_data;
            rs1_d        = id_rs1;
            rs2_d        = id_rs2;
            rd_d         = id_rd;
            alu_ctl_d    = dec_alu_ctl;
            valid_d      = 1'b1;
            illegal_d    = dec_illegal;
            alu_src_d    = id_alu_src;
            mem_read_d   = id_mem_read;
            mem_write_d  = id_mem_write;
            reg_write_d  = id_reg_write;
            mem_to_reg_d = id_mem_to_reg;
            branch_d     = id_branch;
        end
    end

    // Register bank with synchronous reset that also clears the stall counter.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            alu_b_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            alu_ctl_q     <= '0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
            alu_src_q     <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            branch_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            alu_b_q       <= alu_b_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            alu_ctl_q     <= alu_ctl_d;
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
            alu_src_q     <= alu_src_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            branch_q      <= branch_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_pc         = pc_q;
    assign ex_rs1_data   = rs1_data_q;
    assign ex_rs2_data   = rs2_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_alu_src    = alu_src_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_branch     = branch_q;
    assign ex_valid      = valid_q;
    assign ex_alu_ctl    = alu_ctl_q;
    assign ex_alu_b      = alu_b_q;
    assign ex_illegal    = illegal_q;
    assign stall_count   = stall_count_q;

endmodule : id_ex_stage_reg

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg. The stimulus process drives one set of
// inputs per cycle and pushes the state the register must hold after the next
// edge; the monitor pops and compares on every falling edge.
module tb_id_ex_stage_reg;

    localparam int XLEN = 64;
    localparam int REGW = 5;
    localparam int CNTW = 8;   // narrow counter so saturation is reachable quickly
    localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

    typedef struct {
        logic            rst, v, st, fl;
        logic [XLEN-1:0] pc, r1d, r2d, imm;
        logic [REGW-1:0] r1, r2, rd;
        logic [3:0]      funct;
        logic [1:0]      op;
        logic            src, mr, mw, rw, m2r, br;
    } in_t;

    typedef struct {
        logic            valid, illegal;
        logic [XLEN-1:0] pc, r1d, r2d, imm, alu_b;
        logic [REGW-1:0] r1, r2, rd;
        logic [3:0]      ctl;
        logic            src, mr, mw, rw, m2r, br;
        longint          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset, in_valid, stall, flush;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REGW-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0] id_funct;
    logic [1:0] id_alu_op;
    logic id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_b;
    logic [REGW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic ex_valid, ex_illegal;
    logic [3:0] ex_alu_ctl;
    logic [CNTW-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t model;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_valid(ex_valid),
        .ex_alu_ctl(ex_alu_ctl), .ex_alu_b(ex_alu_b), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU control table: {ctl, illegal} for an alu_op class and funct.
    function automatic logic [4:0] ref_ctl(input logic [1:0] op, input logic [3:0] funct);
        if (op == 2'd0) return {4'd2, 1'b0};
        if (op == 2'd1) return {4'd6, 1'b0};
        if (op == 2'd3) return {4'd12, 1'b0};
        if (funct == 4'd0) return {4'd2, 1'b0};
        if (funct == 4'd8) return {4'd6, 1'b0};
        if (funct == 4'd7) return {4'd0, 1'b0};
        if (funct == 4'd6) return {4'd1, 1'b0};
        return {4'd15, 1'b1};
    endfunction

    function automatic exp_t bubble(input longint cnt);
        exp_t e;
        e = '{valid: 0, illegal: 0, pc: 0, r1d: 0, r2d: 0, imm: 0, alu_b: 0, r1: 0, r2: 0, rd: 0,
              ctl: 0, src: 0, mr: 0, mw: 0, rw: 0, m2r: 0, br: 0, cnt: cnt};
        return e;
    endfunction

    // Behavioural next-state rule: reset > flush > stall > load (invalid load = bubble).
    function automatic exp_t next_state(input exp_t cur, input in_t x);
        exp_t n;
        logic [4:0] d;
        if (x.rst) return bubble(0);
        if (x.fl) return bubble(cur.cnt);
        if (x.st) begin
            n = cur;
            if (n.cnt < CNT_MAX) n.cnt = n.cnt + 1;
            return n;
        end
        if (!x.v) return bubble(cur.cnt);
        d = ref_ctl(x.op, x.funct);
        n.valid = 1'b1; n.illegal = d[0]; n.ctl = d[4:1];
        n.pc = x.pc; n.r1d = x.r1d; n.r2d = x.r2d; n.imm = x.imm;
        n.alu_b = x.src ? x.imm : x.r2d;
        n.r1 = x.r1; n.r2 = x.r2; n.rd = x.rd;
        n.src = x.src; n.mr = x.mr; n.mw = x.mw; n.rw = x.rw; n.m2r = x.m2r; n.br = x.br;
        n.cnt = cur.cnt;
        return n;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        logic [3:0] legal [4];
        legal = '{4'd0, 4'd8, 4'd7, 4'd6};
        x.rst = 0; x.st = 0; x.fl = 0; x.v = 1;
        x.pc = {$urandom, $urandom}; x.r1d = {$urandom, $urandom};
        x.r2d = {$urandom, $urandom}; x.imm = {$urandom, $urandom};
        x.r1 = REGW'($urandom); x.r2 = REGW'($urandom); x.rd = REGW'($urandom);
        x.op = 2'($urandom);
        x.funct = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal[$urandom_range(0, 3)];
        x.src = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom);
        x.rw = 1'($urandom); x.m2r = 1'($urandom); x.br = 1'($urandom);
        return x;
    endfunction

    // Apply one cycle of stimulus, record the expected post-edge state, wait for the check.
    task automatic step(input in_t x);
        reset = x.rst; in_valid = x.v; stall = x.st; flush = x.fl;
        id_pc = x.pc; id_rs1_data = x.r1d; id_rs2_data = x.r2d; id_imm = x.imm;
        id_rs1 = x.r1; id_rs2 = x.r2; id_rd = x.rd; id_funct = x.funct; id_alu_op = x.op;
        id_alu_src = x.src; id_mem_read = x.mr; id_mem_write = x.mw;
        id_reg_write = x.rw; id_mem_to_reg = x.m2r; id_branch = x.br;
        model = next_state(model, x);
        sb.push_back(model);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare the registered state against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ex_valid", XLEN'(ex_valid), XLEN'(e.valid));
                check("ex_illegal", XLEN'(ex_illegal), XLEN'(e.illegal));
                check("ex_alu_ctl", XLEN'(ex_alu_ctl), XLEN'(e.ctl));
                check("ex_alu_b", ex_alu_b, e.alu_b);
                check("ex_pc", ex_pc, e.pc);
                check("ex_rs1_data", ex_rs1_data, e.r1d);
                check("ex_rs2_data", ex_rs2_data, e.r2d);
                check("ex_imm", ex_imm, e.imm);
                check("ex_regs", XLEN'({ex_rs1, ex_rs2, ex_rd}), XLEN'({e.r1, e.r2, e.rd}));
                check("ex_ctrl", XLEN'({ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch}),
                      XLEN'({e.src, e.mr, e.mw, e.rw, e.m2r, e.br}));
                check("stall_count", XLEN'(stall_count), XLEN'(e.cnt));
            end
        end
    end

    initial begin
        in_t x;
        model = bubble(0);
        #1;
        // Reset.
        x = rand_in(); x.rst = 1; step(x); step(x);
        // R-type ADD: rs1=5, rs2=7.
        x = rand_in(); x.op = 2'b10; x.funct = 4'b0000; x.r1d = 64'd5; x.r2d = 64'd7; x.src = 0; step(x);
        // I-type with negative immediate.
        x = rand_in(); x.op = 2'b00; x.src = 1; x.imm = 64'hFFFF_FFFF_FFFF_FFF0; step(x);
        // SUB, then three stalls with changing inputs, then a fresh load.
        x = rand_in(); x.op = 2'b10; x.funct = 4'b1000; step(x);
        repeat (3) begin x = rand_in(); x.st = 1; step(x); end
        x = rand_in(); step(x);
        // Stall and flush together.
        x = rand_in(); x.st = 1; x.fl = 1; step(x);
        // Undecodable funct, valid and then invalid.
        x = rand_in(); x.op = 2'b10; x.funct = 4'b0011; step(x);
        x.v = 0; step(x);
        // Reset arriving mid-stall.
        x = rand_in(); step(x);
        x = rand_in(); x.st = 1; step(x);
        x = rand_in(); x.st = 1; x.rst = 1; step(x);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            x = rand_in();
            x.v   = ($urandom_range(0, 4) != 0);
            x.st  = ($urandom_range(0, 3) == 0);
            x.fl  = ($urandom_range(0, 7) == 0);
            x.rst = ($urandom_range(0, 49) == 0);
            step(x);
        end
        // Drive the counter to saturation, stall past it, then reset.
        x = rand_in(); x.rst = 1; step(x);
        for (int i = 0; i < int'(CNT_MAX) + 3; i++) begin x = rand_in(); x.st = 1; step(x); end
        x = rand_in(); x.rst = 1; step(x);
        check("scoreboard_drained", XLEN'(sb.size()), XLEN'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_id_ex_stage_reg
